pio_debounce_irq: RTL and testbench
===================================

PIO_DEBOUNCE_IRQ -- requirements
Module: pio_debounce_irq

Interface
REQ-001 Parameter WIDTH, default 8, number of input and output bits (1..32).
REQ-002 Parameter DEBOUNCE_CYCLES, default 50000, number of stable clocks before an input change is accepted (2..2^20).
REQ-003 Parameter OUT_RESET, default 0, WIDTH-bit reset value of the output register.
REQ-004 Port clk, input, 1, single system clock (50 MHz board clock).
REQ-005 Port reset, input, 1, synchronous, active-high reset.
REQ-006 Port address, input, 3, word address of the slave register.
REQ-007 Port chipselect, input, 1, slave select.
REQ-008 Port read, input, 1, read strobe.
REQ-009 Port write, input, 1, write strobe.
REQ-010 Port writedata, input, 32, write data.
REQ-011 Port readdata, output, 32, registered read data.
REQ-012 Port readdatavalid, output, 1, read data qualifier.
REQ-013 Port in_port, input, WIDTH, asynchronous switch/key inputs.
REQ-014 Port out_port, output, WIDTH, LED/output drive.
REQ-015 Port irq, output, 1, level interrupt request.

Function
REQ-016 Register map (addr): 0 DATA (RO, debounced inputs); 1 OUT (RW); 2 IRQ_MASK (RW); 3 EDGE_CAPTURE (RO, write-1-to-clear); 4 OUT_SET (WO, OUT |= wd); 5 OUT_CLEAR (WO, OUT &= ~wd); 6 EDGE_SEL (RW, per bit 0 = rising, 1 = falling); 7 reserved.
REQ-017 An access occurs only when chipselect is high; read and write in the same cycle is a write plus a read of the pre-write value.
REQ-018 Read latency is exactly 1 cycle: readdatavalid pulses high for one cycle after each accepted read; readdata returns 0 at all other times.
REQ-019 Bits [31:WIDTH] read as 0; write-only and reserved addresses read as 0; writes to addr 0 and 7 are ignored.
REQ-020 Each in_port bit passes through a 2-flop synchroniser before debounce.
REQ-021 Per bit: while the synchronised value equals the debounced value, the counter is held at 0.
REQ-022 Per bit: while they differ, the counter increments each clock; when the counter reaches DEBOUNCE_CYCLES-1, the debounced bit takes the synchronised value on that clock and the counter returns to 0.
REQ-023 Per bit: any return to equality before terminal count clears the counter, so glitches shorter than DEBOUNCE_CYCLES are rejected.
REQ-024 Per bit: a debounced transition matching EDGE_SEL sets the corresponding EDGE_CAPTURE bit on the clock after the debounced update.
REQ-025 When a set event and a write-1-to-clear on the same bit coincide, the bit is set.
REQ-026 irq is registered: irq = |(EDGE_CAPTURE & IRQ_MASK), one clock after the register state.
REQ-027 out_port is driven directly from the OUT register and changes the clock after the write.

Reset
REQ-028 While reset is high at a clk edge:
- OUT = OUT_RESET; IRQ_MASK, EDGE_CAPTURE, EDGE_SEL = 0.
- Synchronisers, debounced values and counters = 0.
- readdata = 0, readdatavalid = 0, irq = 0.
REQ-029 Reset asserted mid-debounce or during a read discards the pending update and the pending readdatavalid.
REQ-030 The first access is accepted on the first clock after reset deasserts.

Verification (WIDTH=8, DEBOUNCE_CYCLES=4, OUT_RESET=8'hA5)
REQ-031 Reset then read addr 1 and addr 0 -> readdata 0x000000A5 then 0x00000000, each with a one-cycle readdatavalid; out_port = 8'hA5; irq = 0.
REQ-032 Write OUT=0x0F, OUT_SET=0x30, OUT_CLEAR=0x01 -> out_port = 0x0F, then 0x3F, then 0x3E; read addr 4 -> readdata 0.
REQ-033 in_port[0] high for 3 clocks then low -> DATA stays 0x00; in_port[0] held high -> DATA = 0x01 within 2 sync + 4 clocks.
REQ-034 IRQ_MASK=0x01, EDGE_SEL=0, in_port[0] rising then stable -> EDGE_CAPTURE = 0x01 and irq = 1; write 0x01 to addr 3 -> irq = 0.
REQ-035 EDGE_SEL=0x02, falling edge on bit 1 lands on the same clock as a W1C of 0x02 -> EDGE_CAPTURE bit 1 remains 1.
REQ-036 Reset pulsed on clock 2 of a 4-clock debounce -> DATA = 0 and the counter restarts from 0.

Source files
------------

// File: rtl/pio_debounce_irq.sv
// ============================================================================
// Module   : pio_debounce_irq
// Brief    : Memory-mapped PIO slave with per-bit input debounce, output
//            register with set/clear aliases, and edge-capture interrupt.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pio_debounce_irq #(
    parameter int          WIDTH           = 8,
    parameter int          DEBOUNCE_CYCLES = 50000,
    parameter logic [WIDTH-1:0] OUT_RESET  = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        address,
    input  logic              chipselect,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              readdatavalid,
    input  logic [WIDTH-1:0]  in_port,
    output logic [WIDTH-1:0]  out_port,
    output logic              irq
);

    localparam int c_CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_TERM = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [2:0] c_ADDR_DATA     = 3'd0;
    localparam logic [2:0] c_ADDR_OUT      = 3'd1;
    localparam logic [2:0] c_ADDR_IRQ_MASK = 3'd2;
    localparam logic [2:0] c_ADDR_EDGE_CAP = 3'd3;
    localparam logic [2:0] c_ADDR_OUT_SET  = 3'd4;
    localparam logic [2:0] c_ADDR_OUT_CLR  = 3'd5;
    localparam logic [2:0] c_ADDR_EDGE_SEL = 3'd6;

    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] r_irq_mask;
    logic [WIDTH-1:0] r_edge_cap;
    logic [WIDTH-1:0] r_edge_sel;
    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_deb_d;
    logic [31:0]      r_readdata;
    logic             r_readdatavalid;
    logic             r_irq;

    logic [WIDTH-1:0] w_deb;
    logic [WIDTH-1:0] w_wd;
    logic [WIDTH-1:0] w_edge_evt;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] w_rd_word;
    logic             w_wr;
    logic             w_rd;

    assign w_wr = chipselect & write;
    assign w_rd = chipselect & read;
    assign w_wd = writedata[WIDTH-1:0];

    generate
        if (WIDTH < 32) begin : g_unused_wd
            logic w_unused_wd;
            assign w_unused_wd = ^writedata[31:WIDTH];
        end
    endgenerate

    // Two-flop synchroniser in front of the debounce counters
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= in_port;
            r_sync2 <= r_sync1;
        end
    end

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            logic [c_CNT_W-1:0] r_cnt;
            logic               r_bit;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_cnt <= '0;
                    r_bit <= 1'b0;
                end else if (r_sync2[i] == r_bit) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_TERM) begin
                    r_cnt <= '0;
                    r_bit <= r_sync2[i];
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            assign w_deb[i] = r_bit;
        end
    endgenerate

    // Delayed copy of the debounced vector so edges are seen one clock after the update
    always_ff @(posedge clk) begin
        if (reset) begin
            r_deb_d <= '0;
        end else begin
            r_deb_d <= w_deb;
        end
    end

    assign w_edge_evt = (w_deb & ~r_deb_d & ~r_edge_sel) |
                        (~w_deb & r_deb_d & r_edge_sel);
    assign w_clr      = (w_wr && (address == c_ADDR_EDGE_CAP)) ? w_wd : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out      <= OUT_RESET;
            r_irq_mask <= '0;
            r_edge_sel <= '0;
        end else if (w_wr) begin
            case (address)
                c_ADDR_OUT:      r_out      <= w_wd;
                c_ADDR_OUT_SET:  r_out      <= r_out | w_wd;
                c_ADDR_OUT_CLR:  r_out      <= r_out & ~w_wd;
                c_ADDR_IRQ_MASK: r_irq_mask <= w_wd;
                c_ADDR_EDGE_SEL: r_edge_sel <= w_wd;
                default: ;
            endcase
        end
    end

    // A new edge wins over a simultaneous write-1-to-clear
    always_ff @(posedge clk) begin
        if (reset) begin
            r_edge_cap <= '0;
        end else begin
            r_edge_cap <= (r_edge_cap & ~w_clr) | w_edge_evt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |(r_edge_cap & r_irq_mask);
        end
    end

    always_comb begin
        w_rd_word = '0;
        case (address)
            c_ADDR_DATA:     w_rd_word = w_deb;
            c_ADDR_OUT:      w_rd_word = r_out;
            c_ADDR_IRQ_MASK: w_rd_word = r_irq_mask;
            c_ADDR_EDGE_CAP: w_rd_word = r_edge_cap;
            c_ADDR_EDGE_SEL: w_rd_word = r_edge_sel;
            default:         w_rd_word = '0;
        endcase
    end

    // Register values are sampled before this edge's write takes effect
    always_ff @(posedge clk) begin
        if (reset) begin
            r_readdata      <= '0;
            r_readdatavalid <= 1'b0;
        end else begin
            r_readdatavalid <= w_rd;
            r_readdata      <= w_rd ? 32'(w_rd_word) : 32'd0;
        end
    end

    assign readdata      = r_readdata;
    assign readdatavalid = r_readdatavalid;
    assign out_port      = r_out;
    assign irq           = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_pio_debounce_irq.sv
// ============================================================================
// Module   : tb_pio_debounce_irq
// Brief    : Directed self-checking bench for pio_debounce_irq (WIDTH=8,
//            DEBOUNCE_CYCLES=4, OUT_RESET=8'hA5).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pio_debounce_irq;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        readdatavalid;
    logic [7:0]  in_port;
    logic [7:0]  out_port;
    logic        irq;

    int n_pass  = 0;
    int n_total = 0;
    logic [31:0] rd;

    pio_debounce_irq #(
        .WIDTH          (8),
        .DEBOUNCE_CYCLES(4),
        .OUT_RESET      (8'hA5)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .address      (address),
        .chipselect   (chipselect),
        .read         (read),
        .write        (write),
        .writedata    (writedata),
        .readdata     (readdata),
        .readdatavalid(readdatavalid),
        .in_port      (in_port),
        .out_port     (out_port),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [2:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write = 1'b1;
        tick(1);
        chipselect = 1'b0; write = 1'b0;
    endtask

    // Two clocks: the data cycle, then a check that the valid pulse is one cycle wide
    task automatic do_read(input logic [2:0] a, output logic [31:0] d);
        address = a; chipselect = 1'b1; read = 1'b1;
        tick(1);
        chipselect = 1'b0; read = 1'b0;
        d = readdata;
        check("rdvalid_pulse", 32'(readdatavalid), 32'd1);
        tick(1);
        check("rdvalid_drop", 32'(readdatavalid), 32'd0);
        check("readdata_idle", readdata, 32'd0);
    endtask

    initial begin
        reset = 1'b1; address = '0; chipselect = 1'b0; read = 1'b0; write = 1'b0;
        writedata = '0; in_port = '0;
        tick(3);
        check("rst_readdata", readdata, 32'd0);
        check("rst_rdvalid", 32'(readdatavalid), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_out_port", 32'(out_port), 32'hA5);
        reset = 1'b0;

        // Reset values through the bus; first access right after reset release
        do_read(3'd1, rd); check("rd_out_reset", rd, 32'h0000_00A5);
        do_read(3'd0, rd); check("rd_data_reset", rd, 32'h0000_0000);
        check("out_port_reset", 32'(out_port), 32'hA5);
        check("irq_idle", 32'(irq), 32'd0);

        // Output register and set/clear aliases
        do_write(3'd1, 32'h0000_000F); check("out_write", 32'(out_port), 32'h0F);
        do_write(3'd4, 32'h0000_0030); check("out_set", 32'(out_port), 32'h3F);
        do_write(3'd5, 32'h0000_0001); check("out_clear", 32'(out_port), 32'h3E);
        do_read(3'd4, rd); check("rd_out_set_wo", rd, 32'd0);
        do_read(3'd7, rd); check("rd_reserved", rd, 32'd0);

        // Simultaneous read+write returns the pre-write value
        address = 3'd1; writedata = 32'hFFFF_FF5A; chipselect = 1'b1; read = 1'b1; write = 1'b1;
        tick(1);
        chipselect = 1'b0; read = 1'b0; write = 1'b0;
        check("rw_pre_value", readdata, 32'h0000_003E);
        check("rw_out_port", 32'(out_port), 32'h5A);
        tick(1);
        do_read(3'd1, rd); check("rd_upper_zero", rd, 32'h0000_005A);
        do_write(3'd0, 32'h0000_00FF);
        do_write(3'd7, 32'h0000_00FF);
        do_read(3'd0, rd); check("data_write_ignored", rd, 32'd0);

        // Three-clock glitch on bit 0 is rejected
        in_port = 8'h01;
        tick(3);
        in_port = 8'h00;
        tick(6);
        do_read(3'd0, rd); check("glitch_rejected", rd, 32'd0);

        // Stable rise on bit 0: visible after 2 sync + 4 debounce clocks
        do_write(3'd2, 32'h0000_0001);
        do_write(3'd6, 32'h0000_0000);
        in_port = 8'h01;
        tick(4);
        do_read(3'd0, rd); check("deb_not_yet", rd, 32'd0);
        do_read(3'd0, rd); check("deb_accepted", rd, 32'h0000_0001);
        check("irq_set", 32'(irq), 32'd1);
        do_read(3'd3, rd); check("edge_cap_rise", rd, 32'h0000_0001);
        do_write(3'd3, 32'h0000_0001);
        check("irq_registered_lag", 32'(irq), 32'd1);
        tick(1);
        check("irq_cleared", 32'(irq), 32'd0);

        // Falling-edge capture on bit 1 colliding with W1C: set wins
        do_write(3'd6, 32'h0000_0002);
        in_port = 8'h03;
        tick(10);
        do_read(3'd3, rd); check("rise_not_selected", rd, 32'd0);
        in_port = 8'h01;
        tick(6);
        do_write(3'd3, 32'h0000_0002);
        do_read(3'd3, rd); check("set_beats_clear", rd, 32'h0000_0002);
        do_write(3'd3, 32'h0000_0002);
        do_read(3'd3, rd); check("w1c_clears", rd, 32'd0);
        check("irq_masked", 32'(irq), 32'd0);

        // Reset mid-debounce and during a pending read
        in_port = 8'h00;
        tick(10);
        in_port = 8'h04;
        tick(2);
        address = 3'd0; chipselect = 1'b1; read = 1'b1;
        tick(1);
        chipselect = 1'b0; read = 1'b0;
        check("pre_reset_rdvalid", 32'(readdatavalid), 32'd1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("reset_kills_rdvalid", 32'(readdatavalid), 32'd0);
        check("reset_readdata", readdata, 32'd0);
        check("reset_out_port", 32'(out_port), 32'hA5);
        tick(5);
        do_read(3'd0, rd); check("deb_restart_not_yet", rd, 32'd0);
        do_read(3'd0, rd); check("deb_restart_done", rd, 32'h0000_0004);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
